// File: rtl/pcie_a7_rate_pkg.sv
// Shared definitions for the Artix-7 PCIe PIPE rate-change controller:
// FSM state encoding, link-rate constants and GT TXRATE codes.
package pcie_a7_rate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TXRATE    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_PCLK      = 3'd3,
    ST_SETTLE    = 3'd4,
    ST_DONE      = 3'd5
  } rate_state_e;

  localparam logic RATE_GEN1 = 1'b0;
  localparam logic RATE_GEN2 = 1'b1;

  localparam logic [2:0] TXRATE_GEN1 = 3'd0;
  localparam logic [2:0] TXRATE_GEN2 = 3'd1;

  // Map a link rate to the GT TXRATE code.
  function automatic logic [2:0] txrate_code(input logic rate);
    return (rate == RATE_GEN2) ? TXRATE_GEN2 : TXRATE_GEN1;
  endfunction

endpackage

// File: rtl/pcie_a7_lane_done_collect.sv
// Per-lane TX/RX rate-done collector. Sticky flags are set by done pulses
// while enabled and cleared synchronously; all_done also counts pulses
// arriving in the current cycle so the FSM can leave without a bubble.
module pcie_a7_lane_done_collect #(
  parameter int PCIE_LANE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PCIE_LANE-1:0] tx_done,
  input  logic [PCIE_LANE-1:0] rx_done,
  output logic                 all_done
);
  import pcie_a7_rate_pkg::*;

  logic [PCIE_LANE-1:0] tx_flag_q, tx_flag_d;
  logic [PCIE_LANE-1:0] rx_flag_q, rx_flag_d;
  logic [PCIE_LANE-1:0] tx_now, rx_now;

  // Merge current pulses into the stored flags and compute the next flags.
  always_comb begin
    tx_now    = en ? (tx_flag_q | tx_done) : tx_flag_q;
    rx_now    = en ? (rx_flag_q | rx_done) : rx_flag_q;
    tx_flag_d = clr ? '0 : tx_now;
    rx_flag_d = clr ? '0 : rx_now;
    all_done  = &(tx_now & rx_now);
  end

  // Sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_flag_q <= '0;
      rx_flag_q <= '0;
    end else begin
      tx_flag_q <= tx_flag_d;
      rx_flag_q <= rx_flag_d;
    end
  end

endmodule

// File: rtl/pcie_a7_4x_pipe_rate_ctrl.sv
// PIPE rate-change controller for the Artix-7 4-lane PCIe PHY wrapper.
// Sequences TXRATE, waits for per-lane rate-done, switches PCLK_SEL, waits
// for PCLK to settle and returns a PHYSTATUS pulse on all lanes.
// Optional build macro PCIE_A7_RATE_TIMEOUT_EN adds a rate-done timeout.
module pcie_a7_4x_pipe_rate_ctrl #(
  parameter int PCIE_LANE       = 4,
  parameter int PCIE_LINK_SPEED = 2,
  parameter int SETTLE_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                 RATE_CLK,
  input  logic                 RATE_RST_N,
  input  logic                 RATE_MMCM_LOCK,
  input  logic [1:0]           RATE_RATE_IN,
  input  logic [PCIE_LANE-1:0] RATE_TXRATEDONE,
  input  logic [PCIE_LANE-1:0] RATE_RXRATEDONE,
  output logic [2:0]           RATE_TXRATE,
  output logic [PCIE_LANE-1:0] RATE_PCLK_SEL,
  output logic                 RATE_GEN3,
  output logic [PCIE_LANE-1:0] RATE_PHYSTATUS,
  output logic                 RATE_IDLE,
  output logic [2:0]           RATE_FSM,
  output logic                 RATE_TIMEOUT
);
  import pcie_a7_rate_pkg::*;

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  rate_state_e          state_q, state_d;
  logic                 cur_rate_q, cur_rate_d;
  logic                 tgt_rate_q, tgt_rate_d;
  logic [2:0]           txrate_q, txrate_d;
  logic [PCIE_LANE-1:0] pclk_sel_q, pclk_sel_d;
  logic [PCIE_LANE-1:0] phystatus_q, phystatus_d;
  logic                 idle_q, idle_d;
  logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic                 req_rate;
  logic                 all_done;

`ifdef PCIE_A7_RATE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
`else
  // TIMEOUT_CYCLES only sizes the timeout counter; keep it referenced here.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
  end
`endif

  // Effective target: Gen2 only when requested and supported.
  assign req_rate = ((PCIE_LINK_SPEED >= 2) && (RATE_RATE_IN == 2'd1)) ? RATE_GEN2 : RATE_GEN1;

  pcie_a7_lane_done_collect #(
    .PCIE_LANE (PCIE_LANE)
  ) u_done (
    .clk      (RATE_CLK),
    .rst_n    (RATE_RST_N),
    .clr      (state_q == ST_TXRATE),
    .en       (state_q == ST_WAIT_DONE),
    .tx_done  (RATE_TXRATEDONE),
    .rx_done  (RATE_RXRATEDONE),
    .all_done (all_done)
  );

  // Next-state and registered-output logic of the rate-change sequence.
  always_comb begin
    state_d      = state_q;
    cur_rate_d   = cur_rate_q;
    tgt_rate_d   = tgt_rate_q;
    txrate_d     = txrate_q;
    pclk_sel_d   = pclk_sel_q;
    phystatus_d  = '0;
    settle_cnt_d = settle_cnt_q;
`ifdef PCIE_A7_RATE_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (RATE_MMCM_LOCK && (req_rate != cur_rate_q)) begin
          tgt_rate_d = req_rate;
          state_d    = ST_TXRATE;
        end
      end
      ST_TXRATE: begin
        txrate_d = txrate_code(tgt_rate_q);
`ifdef PCIE_A7_RATE_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (all_done) begin
          state_d = ST_PCLK;
`ifdef PCIE_A7_RATE_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = ST_PCLK;
          timeout_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
`endif
        end
      end
      ST_PCLK: begin
        pclk_sel_d   = {PCIE_LANE{tgt_rate_q == RATE_GEN2}};
        settle_cnt_d = '0;
        state_d      = ST_SETTLE;
      end
      ST_SETTLE: begin
        // Losing MMCM lock restarts the settle wait from zero.
        if (!RATE_MMCM_LOCK) begin
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SET_LAST) begin
          phystatus_d = '1;
          state_d     = ST_DONE;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      ST_DONE: begin
        cur_rate_d = tgt_rate_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge RATE_CLK or negedge RATE_RST_N) begin
    if (!RATE_RST_N) begin
      state_q      <= ST_IDLE;
      cur_rate_q   <= RATE_GEN1;
      tgt_rate_q   <= RATE_GEN1;
      txrate_q     <= TXRATE_GEN1;
      pclk_sel_q   <= '0;
      phystatus_q  <= '0;
      idle_q       <= 1'b1;
      settle_cnt_q <= '0;
`ifdef PCIE_A7_RATE_TIMEOUT_EN
      to_cnt_q     <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cur_rate_q   <= cur_rate_d;
      tgt_rate_q   <= tgt_rate_d;
      txrate_q     <= txrate_d;
      pclk_sel_q   <= pclk_sel_d;
      phystatus_q  <= phystatus_d;
      idle_q       <= idle_d;
      settle_cnt_q <= settle_cnt_d;
`ifdef PCIE_A7_RATE_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign RATE_TXRATE    = txrate_q;
  assign RATE_PCLK_SEL  = pclk_sel_q;
  assign RATE_GEN3      = 1'b0;
  assign RATE_PHYSTATUS = phystatus_q;
  assign RATE_IDLE      = idle_q;
  assign RATE_FSM       = state_q;
`ifdef PCIE_A7_RATE_TIMEOUT_EN
  assign RATE_TIMEOUT   = timeout_q;
`else
  assign RATE_TIMEOUT   = 1'b0;
`endif

endmodule

// File: tb/tb_pcie_a7_4x_pipe_rate_ctrl.sv
// Directed bench for pcie_a7_4x_pipe_rate_ctrl with a PHYSTATUS scoreboard.
module tb_pcie_a7_4x_pipe_rate_ctrl;

  localparam int L = 4;
  localparam int S = 16;
  localparam int T = 4096;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         lock;
  logic [1:0]   rate_in;
  logic [L-1:0] txd, rxd;

  logic [2:0]   txr, fsm, txr1, fsm1;
  logic [L-1:0] sel, phys, sel1, phys1;
  logic         gen3, idle, tmo, gen3_1, idle1, tmo1;

  pcie_a7_4x_pipe_rate_ctrl #(
    .PCIE_LANE(L), .PCIE_LINK_SPEED(2), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) u_dut (
    .RATE_CLK(clk), .RATE_RST_N(rst_n), .RATE_MMCM_LOCK(lock), .RATE_RATE_IN(rate_in),
    .RATE_TXRATEDONE(txd), .RATE_RXRATEDONE(rxd), .RATE_TXRATE(txr), .RATE_PCLK_SEL(sel),
    .RATE_GEN3(gen3), .RATE_PHYSTATUS(phys), .RATE_IDLE(idle), .RATE_FSM(fsm),
    .RATE_TIMEOUT(tmo)
  );

  pcie_a7_4x_pipe_rate_ctrl #(
    .PCIE_LANE(L), .PCIE_LINK_SPEED(1), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) u_dut_gen1 (
    .RATE_CLK(clk), .RATE_RST_N(rst_n), .RATE_MMCM_LOCK(lock), .RATE_RATE_IN(rate_in),
    .RATE_TXRATEDONE(txd), .RATE_RXRATEDONE(rxd), .RATE_TXRATE(txr1), .RATE_PCLK_SEL(sel1),
    .RATE_GEN3(gen3_1), .RATE_PHYSTATUS(phys1), .RATE_IDLE(idle1), .RATE_FSM(fsm1),
    .RATE_TIMEOUT(tmo1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           cyc;
    logic [L-1:0] sel;
    logic [2:0]   txr;
  } exp_t;
  exp_t sb[$];

  logic gen1_dut_active = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  // Scoreboard: every PHYSTATUS pulse must match the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1 && phys !== '0) begin
      if (sb.size() == 0) begin
        chk("phy_unexpected", 32'(phys), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("phy_cycle", cyc, e.cyc);
        chk("phy_value", 32'(phys), 32'hF);
        chk("phy_pclk_sel", 32'(sel), 32'(e.sel));
        chk("phy_txrate", 32'(txr), 32'(e.txr));
      end
    end
  end

  // The Gen1-only instance must never leave IDLE.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (fsm1 !== 3'd0 || phys1 !== '0 || sel1 !== '0))
      gen1_dut_active <= 1'b1;
  end

  initial begin : stim
    int   c;
    logic tb_cur;
    rst_n = 1'b0; lock = 1'b1; rate_in = 2'd0; txd = '0; rxd = '0;
    tb_cur = 1'b0;
    repeat (3) step();
    chk("rst_txrate", 32'(txr), 32'd0);
    chk("rst_pclk_sel", 32'(sel), 32'd0);
    chk("rst_gen3", 32'(gen3), 32'd0);
    chk("rst_phystatus", 32'(phys), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_fsm", 32'(fsm), 32'd0);
    chk("rst_timeout", 32'(tmo), 32'd0);
    rst_n = 1'b1;
    repeat (4) step();
    chk("hold_gen1_idle", 32'(idle), 32'd1);
    chk("hold_gen1_fsm", 32'(fsm), 32'd0);

    // Gen1 -> Gen2, all done pulses on WAIT_DONE entry.
    c = cyc; rate_in = 2'd1;
    sb.push_back('{c + 4 + S, 4'hF, 3'd1});
    step();
    chk("g2_fsm_txrate", 32'(fsm), 32'd1);
    chk("g2_txrate_not_yet", 32'(txr), 32'd0);
    step();
    chk("g2_fsm_wait", 32'(fsm), 32'd2);
    chk("g2_txrate", 32'(txr), 32'd1);
    txd = '1; rxd = '1;
    step();
    txd = '0; rxd = '0;
    chk("g2_fsm_pclk", 32'(fsm), 32'd3);
    chk("g2_sel_not_yet", 32'(sel), 32'd0);
    step();
    chk("g2_fsm_settle", 32'(fsm), 32'd4);
    chk("g2_sel", 32'(sel), 32'hF);
    wait_cyc(c + 4 + S);
    chk("g2_fsm_done", 32'(fsm), 32'd5);
    chk("g2_not_idle", 32'(idle), 32'd0);
    step();
    chk("g2_idle_after", 32'(idle), 32'd1);
    chk("g2_phy_one_cycle", 32'(phys), 32'd0);
    tb_cur = 1'b1;

    // Gen2 -> Gen1 with staggered done pulses, lane 3 RX last.
    c = cyc; rate_in = 2'd0;
    sb.push_back('{c + 52 + 18, 4'h0, 3'd0});
    wait_cyc(c + 2); txd = '1; step(); txd = '0;
    wait_cyc(c + 5); rxd = 4'h7; step(); rxd = '0;
    wait_cyc(c + 51);
    chk("stag_waiting", 32'(fsm), 32'd2);
    wait_cyc(c + 52);
    rxd = 4'h8;
    chk("stag_still_waiting", 32'(fsm), 32'd2);
    step();
    rxd = '0;
    chk("stag_pclk", 32'(fsm), 32'd3);
    wait_cyc(c + 71);
    chk("stag_sel_gen1", 32'(sel), 32'd0);
    chk("stag_txrate_gen1", 32'(txr), 32'd0);
    chk("stag_idle", 32'(idle), 32'd1);
    tb_cur = 1'b0;

    // Rate code 3 maps to Gen1, which is already current.
    rate_in = 2'd3;
    repeat (8) step();
    chk("same_rate_fsm", 32'(fsm), 32'd0);
    chk("same_rate_idle", 32'(idle), 32'd1);

    // Request blocked while MMCM unlocked.
    lock = 1'b0; rate_in = 2'd1;
    repeat (5) step();
    chk("unlocked_fsm", 32'(fsm), 32'd0);

    // Lock high: request starts; lock drops 3 cycles mid-SETTLE; request toggles.
    c = cyc; lock = 1'b1;
    sb.push_back('{c + 11 + S, 4'hF, 3'd1});
    wait_cyc(c + 2); txd = '1; rxd = '1; step(); txd = '0; rxd = '0;
    wait_cyc(c + 5); rate_in = 2'd0;
    wait_cyc(c + 6);
    chk("toggle_ignored_fsm", 32'(fsm), 32'd4);
    chk("toggle_ignored_sel", 32'(sel), 32'hF);
    wait_cyc(c + 8); lock = 1'b0;
    wait_cyc(c + 11); lock = 1'b1;
    wait_cyc(c + 20);
    chk("settle_restarted", 32'(fsm), 32'd4);
    // Pending Gen1 request runs right after returning to IDLE.
    sb.push_back('{c + 30 + 18, 4'h0, 3'd0});
    wait_cyc(c + 28);
    chk("b2b_idle_between", 32'(fsm), 32'd0);
    step();
    chk("b2b_txrate_state", 32'(fsm), 32'd1);
    wait_cyc(c + 30); txd = '1; rxd = '1; step(); txd = '0; rxd = '0;
    wait_cyc(c + 49);
    chk("b2b_sel_gen1", 32'(sel), 32'd0);
    chk("b2b_idle", 32'(idle), 32'd1);
    tb_cur = 1'b0;

`ifdef PCIE_A7_RATE_TIMEOUT_EN
    // Lane 0 TX done never arrives.
    c = cyc; rate_in = 2'd1;
    sb.push_back('{c + T + 19, 4'hF, 3'd1});
    wait_cyc(c + 2); txd = 4'hE; rxd = '1; step(); txd = '0; rxd = '0;
    wait_cyc(c + T + 1);
    chk("to_not_yet", 32'(tmo), 32'd0);
    chk("to_still_waiting", 32'(fsm), 32'd2);
    step();
    chk("to_set", 32'(tmo), 32'd1);
    chk("to_pclk", 32'(fsm), 32'd3);
    wait_cyc(c + T + 30);
    chk("to_sticky", 32'(tmo), 32'd1);
    chk("to_sel", 32'(sel), 32'hF);
    chk("to_idle", 32'(idle), 32'd1);
    tb_cur = 1'b1;
`else
    chk("timeout_tied_low", 32'(tmo), 32'd0);
`endif

    // Reset in the middle of SETTLE.
    c = cyc; rate_in = tb_cur ? 2'd0 : 2'd1;
    wait_cyc(c + 2); txd = '1; rxd = '1; step(); txd = '0; rxd = '0;
    wait_cyc(c + 5);
    chk("mid_fsm_settle", 32'(fsm), 32'd4);
    chk("mid_sel", 32'(sel), tb_cur ? 32'h0 : 32'hF);
    rate_in = 2'd0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 32'(sel), 32'd0);
    chk("mid_rst_fsm", 32'(fsm), 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_txrate", 32'(txr), 32'd0);
    chk("mid_rst_timeout", 32'(tmo), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (30) step();
    chk("post_rst_fsm", 32'(fsm), 32'd0);
    chk("post_rst_sel", 32'(sel), 32'd0);

    chk("gen1_only_no_activity", 32'(gen1_dut_active), 32'd0);
    chk("gen1_only_txrate", 32'(txr1), 32'd0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_a7_4x_pipe_rate_ctrl.md
# pcie_a7_4x_pipe_rate_ctrl

PIPE rate-change controller for the Artix-7 PCIe 4-lane PHY wrapper. Drives the pipe clock module's per-lane `PCLK_SEL` and `GEN3` inputs, and the GT `TXRATE`, in response to a requested link rate. It collects per-lane GT rate-done handshakes and waits for PCLK to settle after the switch, then returns a per-lane `PHYSTATUS` pulse to the PCIe core. It sits between the core's PIPE rate output and the pipe clock module, and runs on the PCLK domain.

## Interface
Parameters:
- `PCIE_LANE`, 4: number of lanes.
- `PCIE_LINK_SPEED`, 2: maximum supported rate (1 = Gen1 only, 2 = Gen1/Gen2).
- `SETTLE_CYCLES`, 16: PCLK settle wait after a `PCLK_SEL` change (≥1).
- `TIMEOUT_CYCLES`, 4096: rate-done wait limit (only used when the timeout feature is compiled in).

Ports:
- `RATE_CLK`  in  1  PCLK; single clock for the block.
- `RATE_RST_N`  in  1  reset, asynchronous, active-low.
- `RATE_MMCM_LOCK`  in  1  pipe clock MMCM locked.
- `RATE_RATE_IN`  in  2  requested rate: 0 = Gen1, 1 = Gen2; any other value is treated as Gen1.
- `RATE_TXRATEDONE`  in  `PCIE_LANE`  GT TX rate-done pulses.
- `RATE_RXRATEDONE`  in  `PCIE_LANE`  GT RX rate-done pulses.
- `RATE_TXRATE`  out  3  GT rate code: 3'd0 = Gen1, 3'd1 = Gen2.
- `RATE_PCLK_SEL`  out  `PCIE_LANE`  to pipe clock `CLK_PCLK_SEL`; 1 = Gen2 PCLK.
- `RATE_GEN3`  out  1  to pipe clock `CLK_GEN3`; constant 0.
- `RATE_PHYSTATUS`  out  `PCIE_LANE`  one-cycle rate-change-complete pulse, all lanes together.
- `RATE_IDLE`  out  1  high in IDLE.
- `RATE_FSM`  out  3  current state encoding (debug).
- `RATE_TIMEOUT`  out  1  sticky rate-done timeout flag.

## Operation
**Effective target rate**
- Target = Gen2 only when `RATE_RATE_IN` == 1 and `PCIE_LINK_SPEED` ≥ 2; otherwise Gen1.
- The current-rate register resets to Gen1.

**State machine** (encodings 0–5):
- IDLE(0): when `RATE_MMCM_LOCK` = 1 and target ≠ current, latch target and go to TXRATE. With lock low, no request is accepted.
- TXRATE(1): drive `RATE_TXRATE` with the latched target code; clear the lane-done flags; go to WAIT_DONE.
- WAIT_DONE(2): per-lane sticky flags are set on TX done and on RX done. Exit to PCLK when every lane has both flags set, counting flags already stored plus pulses arriving this cycle.
- PCLK(3): register `RATE_PCLK_SEL` = {`PCIE_LANE`{target==Gen2}}; go to SETTLE.
- SETTLE(4): count `SETTLE_CYCLES`, then go to DONE. `RATE_MMCM_LOCK` low restarts the count at 0.
- DONE(5): assert `RATE_PHYSTATUS` = all ones for 1 cycle; current ← target; go to IDLE.

**Boundary behaviour**
- `RATE_RATE_IN` changes during a sequence are ignored; they are re-evaluated in IDLE, so back-to-back requests run as consecutive sequences.
- Done pulses in any state other than WAIT_DONE are ignored.
- Requesting the rate already current produces no activity and no `PHYSTATUS`.
- Reset mid-sequence returns everything to reset values immediately. `RATE_PCLK_SEL` reverts to Gen1.

## Timing
- Reset values: `RATE_TXRATE` = 0, `RATE_PCLK_SEL` = 0, `RATE_GEN3` = 0, `RATE_PHYSTATUS` = 0, `RATE_IDLE` = 1, `RATE_FSM` = 0, `RATE_TIMEOUT` = 0.
- All outputs are registered.
- Request visible at cycle 0, with all done flags present on WAIT_DONE entry:
  - TXRATE at cycle 1; `RATE_TXRATE` is valid from cycle 2.
  - WAIT_DONE at cycle 2.
  - PCLK at cycle 3; `RATE_PCLK_SEL` changes at cycle 4.
  - SETTLE from cycle 4 to cycle 3+`SETTLE_CYCLES`.
  - `RATE_PHYSTATUS` high at cycle 4+`SETTLE_CYCLES`.
  - `RATE_IDLE` high again the following cycle.
- `RATE_TXRATE` holds its value between sequences.

## Configuration
Macro: `PCIE_A7_RATE_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT_DONE.
  - After `TIMEOUT_CYCLES` cycles without all flags set, the FSM proceeds to PCLK anyway and sets `RATE_TIMEOUT`.
  - `RATE_TIMEOUT` is sticky until reset.
- Undefined:
  - WAIT_DONE waits indefinitely.
  - `RATE_TIMEOUT` is tied to 0 and no counter is built.

## Structure
- Package `pcie_a7_rate_pkg`:
  - state encoding typedef (IDLE..DONE);
  - constants `RATE_GEN1` / `RATE_GEN2` and the TXRATE codes 3'd0 / 3'd1.
- Sub-module `pcie_a7_lane_done_collect`:
  - per-lane TX/RX sticky flags with synchronous clear;
  - `all_done` output that includes the current-cycle pulses.

## Test plan
- Reset, hold Gen1, lock high → outputs at reset values, `RATE_IDLE` = 1, no `RATE_PHYSTATUS`.
- Request Gen2, all 4 lanes pulse TX/RX done together on WAIT_DONE entry, `SETTLE_CYCLES` = 16 → `RATE_TXRATE` = 1, `RATE_PCLK_SEL` = 4'b1111, `RATE_PHYSTATUS` = 4'b1111 exactly 20 cycles after the request.
- Staggered done pulses (lane 3 RX last, 50 cycles late) → stays in WAIT_DONE until that pulse, then proceeds; then Gen2→Gen1 → `RATE_PCLK_SEL` = 0.
- `PCIE_LINK_SPEED` = 1, request Gen2 → no sequence and no `PHYSTATUS`.
- Lock drops for 3 cycles mid-SETTLE → settle count restarts and `PHYSTATUS` is delayed accordingly; toggling the request mid-sequence has no effect until IDLE.
- With `PCIE_A7_RATE_TIMEOUT_EN`, lane 0 TX done never arrives → after 4096 cycles `RATE_TIMEOUT` = 1, the sequence completes, and the flag stays set until reset.
